wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Final pipeline stage, fed by the memory stage.
//  - Retires instructions and writes the register file.
//  - Holds the CP0 registers: Status, Cause, EPC and, optionally, Count/Compare.
//  - Turns a retiring exception or eret into a one-cycle flush, with its redirect PC, for all earlier stages.
//  - Returns forwarding buses to the MEM and ID stages.
// PARAMETERS
//  EX_ENTRY   32'hBFC0_0380  exception handler address
//  STATUS_RST 32'h0040_0000  Status reset value (BEV=1)
// PORTS
//  clk             in   1   clock
//  reset           in   1   synchronous, active-high
//  ms_to_ws_valid  in   1   MEM stage holds a valid instruction
//  ms_to_ws_bus    in   83  {in_slot,exc,cp0_addr[7:0],eret,mfc0,mtc0,gr_we,dest[4:0],result[31:0],pc[31:0]}
//  ws_allowin      out  1   always 1 (single-cycle stage)
//  ws_to_ms_bus    out  37  {dest[4:0],final_result[31:0]}; dest=0 when no write
//  ws_to_ds_bus    out  39  {ws_valid,rf_we,dest[4:0],final_result[31:0]}
//  exception_bus   out  33  {flush,ex_pc[31:0]}
//  rf_we           out  1   register-file write enable
//  rf_waddr        out  5   write address
//  rf_wdata        out  32  write data
//  debug_wb_pc     out  32  PC of the retiring instruction
//  debug_wb_rf_wen out  4   {4{rf_we}}
//  debug_wb_rf_wnum/wdata out 5/32  copies of rf_waddr/rf_wdata
// BEHAVIOUR
//  - ws_valid and the bus register: reset->0.
//    - If flush=1, ws_valid<=0 (this drops the younger instruction MEM hands over at the same edge).
//    - Otherwise ws_valid<=ms_to_ws_valid, and the bus register loads whenever ms_to_ws_valid=1.
//  - Latency: 1 cycle from MEM to register-file write. rf_we=ws_valid & gr_we & ~exc & ~eret & ~mtc0.
//  - final_result = mfc0 ? cp0_rdata : result. It is also driven on both forwarding buses.
//  - flush = ws_valid & (exc|eret). Combinational, one cycle only.
//    - ex_pc = exc ? EX_ENTRY : EPC.
//    - When flush=0, ex_pc is 0.
//  - CP0 addressing uses cp0_addr={rd,sel}: Status=8'h60, Cause=8'h68, EPC=8'h70, Count=8'h48, Compare=8'h58.
//    Reads of any other address return 0.
//  - mtc0 writes at the edge ending the cycle when ws_valid & mtc0 & ~exc.
//    - Status: only IM[15:8], EXL[1] and IE[0] are writable.
//    - Cause: only IP[9:8] is writable.
//    - EPC: all 32 bits are writable.
//  - Exception commit (ws_valid & exc):
//    - Status.EXL<=1.
//    - Cause.ExcCode[6:2]<=5'h08 (Sys) and Cause.BD<=in_slot.
//    - EPC<=in_slot ? pc-4 : pc. This happens even if EXL is already 1.
//  - eret commit sets Status.EXL<=0.
//  - If exc and eret are both set, exc wins: the exception path is taken and EXL stays 1.
//  - If an mtc0 and an exception-side update hit the same field in one cycle, the exception-side update wins.
//  - CP0 reset values: Status=STATUS_RST, Cause=0, EPC=0.
//  - Reset asserted mid-flush: flush drops in the same cycle (ws_valid=0 after the edge) and the CP0 registers return to their reset values.
// CONFIGURATION
//  CP0_TIMER_EN defined:
//    - Count and a 1-bit tick exist. Tick toggles every cycle; Count increments when tick=1 (half clock rate) and wraps from FFFF_FFFF to 0.
//    - mtc0 to Count loads Count and clears tick.
//    - mtc0 to Compare loads Compare and clears Cause.TI[30].
//    - When Count==Compare and Compare is not being written, Cause.TI<=1 and Cause.IP[15]<=1.
//    - All of these reset to 0.
//  CP0_TIMER_EN undefined: Count, Compare and TI do not exist. They read 0 and writes to them are ignored.
// TESTING
//  1. Valid add, dest=5, result=0x1234, pc=0xBFC00010 -> next cycle rf_we=1, waddr=5, wdata=0x1234, flush=0.
//  2. mtc0 to addr 0x70 with result 0xBFC00100, then mfc0 from 0x70 with dest=3 -> wdata=0xBFC00100.
//  3. Syscall: exc=1, in_slot=1, pc=0xBFC00020 -> flush=1 for exactly one cycle, ex_pc=0xBFC00380, rf_we=0, EPC=0xBFC0001C, Cause=0x8000_0020, Status.EXL=1; the instruction following in the same cycle is dropped.
//  4. eret with EPC=0xBFC00100 -> flush=1, ex_pc=0xBFC00100, Status.EXL=0 next cycle.
//  5. CP0_TIMER_EN, Compare=10, Count=0 -> Cause.TI=1 about 20 cycles later; mtc0 to Compare clears TI.
//  6. Reset asserted during a flush cycle -> all outputs 0 next cycle, Status reads 0x0040_0000.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM -> WB handshake bundle: valid, 83-bit instruction bus, and the WB allowin.
interface wb_stage_if;
    logic        ms_to_ws_valid;
    logic [82:0] ms_to_ws_bus;
    logic        ws_allowin;

    modport master (
        output ms_to_ws_valid,
        output ms_to_ws_bus,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid,
        input  ms_to_ws_bus,
        output ws_allowin
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: retires into the register file, holds CP0, raises flush.
// Define CP0_TIMER_EN to build the Count/Compare timer and Cause.TI.
module wb_stage #(
    parameter logic [31:0] EX_ENTRY   = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    wb_stage_if.slave   ms,
    output logic [36:0] ws_to_ms_bus,
    output logic [38:0] ws_to_ds_bus,
    output logic [32:0] exception_bus,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    typedef struct packed {
        logic        in_slot;
        logic        exc;
        logic [7:0]  cp0_addr;
        logic        eret;
        logic        mfc0;
        logic        mtc0;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_ws_t;

    localparam logic [7:0] A_STATUS  = 8'h60;
    localparam logic [7:0] A_CAUSE   = 8'h68;
    localparam logic [7:0] A_EPC     = 8'h70;
    localparam logic [7:0] A_COUNT   = 8'h48;
    localparam logic [7:0] A_COMPARE = 8'h58;

    logic        ws_valid_q, ws_valid_d;
    ms_ws_t      bus_q, bus_d, in_bus;
    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;

    logic        flush;
    logic        exc_commit;
    logic        eret_commit;
    logic        cp0_we;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] final_result;
    logic [31:0] ex_pc;

`ifdef CP0_TIMER_EN
    logic        tick_q, tick_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
`endif

    assign in_bus        = ms.ms_to_ws_bus;
    assign ms.ws_allowin = 1'b1;

    assign exc_commit  = ws_valid_q & bus_q.exc;
    assign eret_commit = ws_valid_q & bus_q.eret & ~bus_q.exc;
    assign flush       = ws_valid_q & (bus_q.exc | bus_q.eret);
    assign cp0_we      = ws_valid_q & bus_q.mtc0 & ~bus_q.exc;
    assign cp0_wdata   = bus_q.result;

    // Flush kills the younger instruction arriving at the same edge.
    always_comb begin
        ws_valid_d = 1'b0;
        bus_d      = bus_q;
        if (!flush) begin
            ws_valid_d = ms.ms_to_ws_valid;
            if (ms.ms_to_ws_valid) begin
                bus_d = in_bus;
            end
        end
    end

    always_comb begin
        status_d = status_q;
        if (cp0_we && bus_q.cp0_addr == A_STATUS) begin
            status_d[15:8] = cp0_wdata[15:8];
            status_d[1:0]  = cp0_wdata[1:0];
        end
        if (exc_commit) begin
            status_d[1] = 1'b1;
        end else if (eret_commit) begin
            status_d[1] = 1'b0;
        end
    end

    always_comb begin
        cause_d = cause_q;
        if (cp0_we && bus_q.cp0_addr == A_CAUSE) begin
            cause_d[9:8] = cp0_wdata[9:8];
        end
        if (exc_commit) begin
            cause_d[31]  = bus_q.in_slot;
            cause_d[6:2] = 5'h08;
        end
`ifdef CP0_TIMER_EN
        if (cp0_we && bus_q.cp0_addr == A_COMPARE) begin
            cause_d[30] = 1'b0;
        end else if (count_q == compare_q) begin
            cause_d[30] = 1'b1;
            cause_d[15] = 1'b1;
        end
`endif
    end

    always_comb begin
        epc_d = epc_q;
        if (cp0_we && bus_q.cp0_addr == A_EPC) begin
            epc_d = cp0_wdata;
        end
        if (exc_commit) begin
            epc_d = bus_q.in_slot ? bus_q.pc - 32'd4 : bus_q.pc;
        end
    end

`ifdef CP0_TIMER_EN
    // Count advances on every other cycle, gated by the tick toggle.
    always_comb begin
        tick_d    = ~tick_q;
        count_d   = count_q + {31'd0, tick_q};
        compare_d = compare_q;
        if (cp0_we && bus_q.cp0_addr == A_COUNT) begin
            count_d = cp0_wdata;
            tick_d  = 1'b0;
        end
        if (cp0_we && bus_q.cp0_addr == A_COMPARE) begin
            compare_d = cp0_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q    <= 1'b0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
        end else begin
            tick_q    <= tick_d;
            count_q   <= count_d;
            compare_q <= compare_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q <= 1'b0;
            bus_q      <= '0;
            status_q   <= STATUS_RST;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
        end else begin
            ws_valid_q <= ws_valid_d;
            bus_q      <= bus_d;
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        unique case (bus_q.cp0_addr)
            A_STATUS:  cp0_rdata = status_q;
            A_CAUSE:   cp0_rdata = cause_q;
            A_EPC:     cp0_rdata = epc_q;
`ifdef CP0_TIMER_EN
            A_COUNT:   cp0_rdata = count_q;
            A_COMPARE: cp0_rdata = compare_q;
`endif
            default:   cp0_rdata = 32'd0;
        endcase
    end

    always_comb begin
        ex_pc = 32'd0;
        if (flush) begin
            ex_pc = bus_q.exc ? EX_ENTRY : epc_q;
        end
    end

    assign final_result = bus_q.mfc0 ? cp0_rdata : bus_q.result;

    assign rf_we    = ws_valid_q & bus_q.gr_we & ~bus_q.exc
                    & ~bus_q.eret & ~bus_q.mtc0;
    assign rf_waddr = bus_q.dest;
    assign rf_wdata = final_result;

    assign ws_to_ms_bus  = {rf_we ? bus_q.dest : 5'd0, final_result};
    assign ws_to_ds_bus  = {ws_valid_q, rf_we, bus_q.dest, final_result};
    assign exception_bus = {flush, ex_pc};

    assign debug_wb_pc       = bus_q.pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed vector bench for wb_stage: retire, CP0 access, flush, reset.
// The timer section is only built when CP0_TIMER_EN is defined.
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic [36:0] ws_to_ms_bus;
    logic [38:0] ws_to_ds_bus;
    logic [32:0] exception_bus;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int n_vec = 0;
    int n_bad = 0;

`ifdef CP0_TIMER_EN
    localparam logic [31:0] TMR = 32'h4000_8000;
`else
    localparam logic [31:0] TMR = 32'h0000_0000;
`endif

    wb_stage_if mif ();

    wb_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms                (mif),
        .ws_to_ms_bus      (ws_to_ms_bus),
        .ws_to_ds_bus      (ws_to_ds_bus),
        .exception_bus     (exception_bus),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [82:0] b;
        logic        ck;
        logic        ev;
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        ef;
        logic [31:0] ex;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [82:0] ib(
        logic s, logic x, logic [7:0] a, logic er, logic mf,
        logic mt, logic we, logic [4:0] d, logic [31:0] r, logic [31:0] pc);
        return {s, x, a, er, mf, mt, we, d, r, pc};
    endfunction

    function automatic logic [82:0] alu(logic [4:0] d, logic [31:0] r,
                                        logic [31:0] pc);
        return ib(0, 0, 8'h00, 0, 0, 0, 1, d, r, pc);
    endfunction

    function automatic logic [82:0] mtc0(logic [7:0] a, logic [31:0] r);
        return ib(0, 0, a, 0, 0, 1, 0, 5'd0, r, 32'hBFC0_0200);
    endfunction

    function automatic logic [82:0] mfc0(logic [7:0] a, logic [4:0] d);
        return ib(0, 0, a, 0, 1, 0, 1, d, 32'd0, 32'hBFC0_0300);
    endfunction

    function automatic vec_t mv(logic v, logic [82:0] b, logic ck, logic ev,
                                logic ew, logic [4:0] ea, logic [31:0] ed,
                                logic ef, logic [31:0] ex);
        vec_t t;
        t.v = v; t.b = b; t.ck = ck; t.ev = ev; t.ew = ew;
        t.ea = ea; t.ed = ed; t.ef = ef; t.ex = ex;
        return t;
    endfunction

    // Plain retire of a one-cycle-old register write.
    function automatic vec_t rd(logic [82:0] b, logic [4:0] d, logic [31:0] e);
        return mv(1, b, 1, 1, 1, d, e, 0, 32'd0);
    endfunction

    function automatic vec_t drop();
        return mv(1, alu(5'd9, 32'h99, 32'hBFC0_0400), 0, 0, 0, 5'd0, 32'd0,
                  0, 32'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic v, input logic [82:0] b);
        mif.ms_to_ws_valid = v;
        mif.ms_to_ws_bus   = b;
    endtask

    task automatic check_zero(input string nm);
        cmp({nm, " rf_we"}, 64'(rf_we), 64'd0);
        cmp({nm, " xbus"}, 64'(exception_bus), 64'd0);
        cmp({nm, " ms_bus"}, 64'(ws_to_ms_bus), 64'd0);
        cmp({nm, " ds_bus"}, 64'(ws_to_ds_bus), 64'd0);
        cmp({nm, " wb_pc"}, 64'(debug_wb_pc), 64'd0);
        cmp({nm, " dbg_wen"}, 64'(debug_wb_rf_wen), 64'd0);
    endtask

    initial begin
        vec_t t;
        reset = 1'b1;
        apply(0, '0);
        tick();
        tick();
        check_zero("reset");
        cmp("allowin", 64'(mif.ws_allowin), 64'd1);
        reset = 1'b0;

        vecs.push_back(rd(alu(5'd5, 32'h1234, 32'hBFC0_0010), 5'd5, 32'h1234));
        vecs.push_back(mv(1, mtc0(8'h70, 32'hBFC0_0100), 1, 1, 0, 5'd0,
                          32'hBFC0_0100, 0, 32'd0));
        vecs.push_back(rd(mfc0(8'h70, 5'd3), 5'd3, 32'hBFC0_0100));
        vecs.push_back(rd(mfc0(8'h60, 5'd4), 5'd4, 32'h0040_0000));
        vecs.push_back(mv(1, mtc0(8'h60, 32'hFFFF_FFFF), 1, 1, 0, 5'd0,
                          32'hFFFF_FFFF, 0, 32'd0));
        vecs.push_back(rd(mfc0(8'h60, 5'd6), 5'd6, 32'h0040_FF03));
        vecs.push_back(mv(1, mtc0(8'h68, 32'hFFFF_FFFF), 1, 1, 0, 5'd0,
                          32'hFFFF_FFFF, 0, 32'd0));
        vecs.push_back(rd(mfc0(8'h68, 5'd7), 5'd7, 32'h0000_0300 | TMR));
        vecs.push_back(mv(1, mtc0(8'h60, 32'd0), 1, 1, 0, 5'd0, 32'd0,
                          0, 32'd0));
        vecs.push_back(rd(mfc0(8'h08, 5'd8), 5'd8, 32'd0));
        // syscall in a delay slot, then the younger instruction is dropped
        vecs.push_back(mv(1, ib(1, 1, 8'h00, 0, 0, 0, 1, 5'd2, 32'h55,
                                32'hBFC0_0020),
                          1, 1, 0, 5'd2, 32'h55, 1, 32'hBFC0_0380));
        vecs.push_back(drop());
        vecs.push_back(rd(mfc0(8'h70, 5'd10), 5'd10, 32'hBFC0_001C));
        vecs.push_back(rd(mfc0(8'h68, 5'd11), 5'd11, 32'h8000_0320 | TMR));
        vecs.push_back(rd(mfc0(8'h60, 5'd12), 5'd12, 32'h0040_0002));
        vecs.push_back(mv(1, mtc0(8'h70, 32'hBFC0_0100), 1, 1, 0, 5'd0,
                          32'hBFC0_0100, 0, 32'd0));
        vecs.push_back(mv(1, ib(0, 0, 8'h00, 1, 0, 0, 0, 5'd0, 32'h77,
                                32'hBFC0_0030),
                          1, 1, 0, 5'd0, 32'h77, 1, 32'hBFC0_0100));
        vecs.push_back(drop());
        vecs.push_back(rd(mfc0(8'h60, 5'd13), 5'd13, 32'h0040_0000));
        // exc and eret together: exception path wins
        vecs.push_back(mv(1, ib(0, 1, 8'h00, 1, 0, 0, 0, 5'd0, 32'd0,
                                32'hBFC0_0040),
                          1, 1, 0, 5'd0, 32'd0, 1, 32'hBFC0_0380));
        vecs.push_back(drop());
        vecs.push_back(rd(mfc0(8'h60, 5'd1), 5'd1, 32'h0040_0002));
        vecs.push_back(rd(mfc0(8'h70, 5'd1), 5'd1, 32'hBFC0_0040));
        vecs.push_back(rd(mfc0(8'h68, 5'd1), 5'd1, 32'h0000_0320 | TMR));
        // mtc0 carrying an exception must not write EPC
        vecs.push_back(mv(1, ib(0, 1, 8'h70, 0, 0, 1, 0, 5'd0, 32'h1234_5678,
                                32'hBFC0_0050),
                          1, 1, 0, 5'd0, 32'h1234_5678, 1, 32'hBFC0_0380));
        vecs.push_back(drop());
        vecs.push_back(rd(mfc0(8'h70, 5'd2), 5'd2, 32'hBFC0_0050));
        vecs.push_back(mv(0, mtc0(8'h70, 32'h0000_DEAD), 0, 0, 0, 5'd0, 32'd0,
                          0, 32'd0));
        vecs.push_back(rd(mfc0(8'h70, 5'd2), 5'd2, 32'hBFC0_0050));
        vecs.push_back(mv(1, ib(0, 0, 8'h00, 1, 0, 0, 0, 5'd0, 32'd0,
                                32'hBFC0_0060),
                          1, 1, 0, 5'd0, 32'd0, 1, 32'hBFC0_0050));
        vecs.push_back(drop());
        vecs.push_back(rd(mfc0(8'h60, 5'd3), 5'd3, 32'h0040_0000));
        vecs.push_back(mv(1, ib(0, 0, 8'h68, 0, 0, 1, 1, 5'd14, 32'd0,
                                32'hBFC0_0070),
                          1, 1, 0, 5'd14, 32'd0, 0, 32'd0));
        vecs.push_back(rd(mfc0(8'h68, 5'd15), 5'd15, 32'h0000_0020 | TMR));

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            apply(t.v, t.b);
            tick();
            cmp($sformatf("v%0d rf_we", i), 64'(rf_we), 64'(t.ew));
            cmp($sformatf("v%0d xbus", i), 64'(exception_bus),
                64'({t.ef, t.ex}));
            cmp($sformatf("v%0d ds_vw", i), 64'(ws_to_ds_bus[38:37]),
                64'({t.ev, t.ew}));
            cmp($sformatf("v%0d dbg_wen", i), 64'(debug_wb_rf_wen),
                64'({4{t.ew}}));
            if (t.ck) begin
                cmp($sformatf("v%0d waddr", i), 64'(rf_waddr), 64'(t.ea));
                cmp($sformatf("v%0d wdata", i), 64'(rf_wdata), 64'(t.ed));
                cmp($sformatf("v%0d ms_bus", i), 64'(ws_to_ms_bus),
                    64'({t.ew ? t.ea : 5'd0, t.ed}));
                cmp($sformatf("v%0d ds_bus", i), 64'(ws_to_ds_bus),
                    64'({t.ev, t.ew, t.ea, t.ed}));
                cmp($sformatf("v%0d wb_pc", i), 64'(debug_wb_pc),
                    64'(t.b[31:0]));
                cmp($sformatf("v%0d dbg_wd", i),
                    64'({debug_wb_rf_wnum, debug_wb_rf_wdata}),
                    64'({t.ea, t.ed}));
            end
        end
        apply(0, '0);
        tick();
        cmp("idle xbus", 64'(exception_bus), 64'd0);

`ifdef CP0_TIMER_EN
        begin
            int  n;
            logic hit;
            apply(1, mtc0(8'h48, 32'd0));
            tick();
            apply(1, mtc0(8'h58, 32'd10));
            tick();
            apply(1, mfc0(8'h68, 5'd1));
            tick();
            cmp("ti cleared", 64'(rf_wdata[30]), 64'd0);
            n   = 0;
            hit = 1'b0;
            while (!hit && n < 60) begin
                tick();
                n++;
                hit = rf_wdata[30];
            end
            cmp("ti set", 64'(hit), 64'd1);
            cmp("ti delay ok", 64'(n >= 15 && n <= 25), 64'd1);
            apply(1, mtc0(8'h58, 32'h100));
            tick();
            apply(1, mfc0(8'h68, 5'd1));
            tick();
            cmp("ti clr by cmp", 64'(rf_wdata[30]), 64'd0);
            apply(0, '0);
            tick();
        end
`endif

        // reset landing on a flush cycle
        apply(1, ib(0, 1, 8'h00, 0, 0, 0, 0, 5'd0, 32'h66, 32'hBFC0_0090));
        tick();
        apply(1, alu(5'd4, 32'h44, 32'hBFC0_0094));
        cmp("rst-flush pre", 64'(exception_bus), 64'({1'b1, 32'hBFC0_0380}));
        reset = 1'b1;
        tick();
        check_zero("rst-flush");
        reset = 1'b0;
        apply(1, mfc0(8'h60, 5'd1));
        tick();
        cmp("rst status", 64'(rf_wdata), 64'h0040_0000);
        apply(1, mfc0(8'h70, 5'd1));
        tick();
        cmp("rst epc", 64'(rf_wdata), 64'd0);
        apply(0, '0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
